// File: rtl/light_phase_ctrl.sv
// Traffic-light phase sequencer: closes the loop with Light_Counter by issuing
// one-hot reload pulses on each phase change, serves pedestrian requests and runs night flash.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   START  | post-reset idle, red lamp, waits for first enabled edge
//   RED    | red lamp, counter running, ped_walk shown if a request was served
//   GREEN  | green lamp, may be cut short by a latched pedestrian request
//   YELLOW | yellow lamp, decides between RED and night-mode FLASH
//   FLASH  | counter idle, yellow lamp blinking until night_mode drops
module light_phase_ctrl #(
    parameter int pINIT_WIDTH = 3,
    parameter int pMIN_GREEN  = 4,
    parameter int pFLASH_HALF = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   last,
    input  logic                   ped_req,
    input  logic                   night_mode,
    output logic [pINIT_WIDTH-1:0] init,
    output logic                   cnt_en,
    output logic [2:0]             light,
    output logic                   ped_walk,
    output logic [2:0]             state_o
);

    localparam int GW = $clog2(pMIN_GREEN + 1);
    localparam int FW = (pFLASH_HALF > 1) ? $clog2(pFLASH_HALF) : 1;

    localparam logic [GW-1:0] GREEN_MAX    = GW'(pMIN_GREEN);
    localparam logic [GW-1:0] GREEN_EXIT   = GW'(pMIN_GREEN - 1);
    localparam logic [FW-1:0] FLASH_RELOAD = FW'(pFLASH_HALF - 1);

    localparam logic [pINIT_WIDTH-1:0] INIT_NONE = '0;
    localparam logic [pINIT_WIDTH-1:0] INIT_RED  = 3'b100;
    localparam logic [pINIT_WIDTH-1:0] INIT_YEL  = 3'b010;
    localparam logic [pINIT_WIDTH-1:0] INIT_GRN  = 3'b001;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

    typedef enum logic [2:0] {
        S_START  = 3'd0,
        S_RED    = 3'd1,
        S_GREEN  = 3'd2,
        S_YELLOW = 3'd3,
        S_FLASH  = 3'd4
    } state_t;

    state_t                   state, state_nxt;
    logic [2:0]               light_nxt;
    logic [pINIT_WIDTH-1:0]   init_nxt;
    logic                     cnt_en_nxt;
    logic                     ped_walk_nxt;
    logic                     ped_latch, ped_latch_nxt;
    logic [GW-1:0]            green_tmr, green_tmr_nxt;
    logic [FW-1:0]            flash_tmr, flash_tmr_nxt;
    logic                     load_ok;

    // A phase may only end once its reload pulse has gone out; this also masks last on init cycles.
    assign load_ok = (init == INIT_NONE);
    assign state_o = state;

    always_comb begin
        state_nxt     = state;
        light_nxt     = light;
        init_nxt      = INIT_NONE;
        cnt_en_nxt    = 1'b0;
        ped_walk_nxt  = ped_walk;
        ped_latch_nxt = ped_latch | (ped_req && (state != S_FLASH));
        green_tmr_nxt = green_tmr;
        flash_tmr_nxt = flash_tmr;

        if (en) begin
            case (state)
                S_START: begin
                    if (night_mode) begin
                        state_nxt     = S_FLASH;
                        light_nxt     = LAMP_YEL;
                        flash_tmr_nxt = FLASH_RELOAD;
                    end else begin
                        state_nxt = S_RED;
                        light_nxt = LAMP_RED;
                        init_nxt  = INIT_RED;
                    end
                end
                S_RED: begin
                    if (load_ok && last) begin
                        state_nxt     = S_GREEN;
                        light_nxt     = LAMP_GRN;
                        init_nxt      = INIT_GRN;
                        green_tmr_nxt = '0;
                        ped_walk_nxt  = 1'b0;
                    end
                end
                S_GREEN: begin
                    if (green_tmr != GREEN_MAX)
                        green_tmr_nxt = green_tmr + 1'b1;
                    // Early exit counts the cycle now ending as served green time.
                    if (load_ok && (last || (ped_latch && (green_tmr >= GREEN_EXIT)))) begin
                        state_nxt = S_YELLOW;
                        light_nxt = LAMP_YEL;
                        init_nxt  = INIT_YEL;
                    end
                end
                S_YELLOW: begin
                    if (load_ok && last) begin
                        if (night_mode) begin
                            state_nxt     = S_FLASH;
                            light_nxt     = LAMP_YEL;
                            flash_tmr_nxt = FLASH_RELOAD;
                        end else begin
                            state_nxt     = S_RED;
                            light_nxt     = LAMP_RED;
                            init_nxt      = INIT_RED;
                            ped_walk_nxt  = ped_latch;
                            ped_latch_nxt = ped_req;
                        end
                    end
                end
                S_FLASH: begin
                    if (!night_mode) begin
                        state_nxt    = S_RED;
                        light_nxt    = LAMP_RED;
                        init_nxt     = INIT_RED;
                        ped_walk_nxt = 1'b0;
                    end else if (flash_tmr == '0) begin
                        light_nxt     = light ^ LAMP_YEL;
                        flash_tmr_nxt = FLASH_RELOAD;
                    end else begin
                        flash_tmr_nxt = flash_tmr - 1'b1;
                    end
                end
                default: begin
                    state_nxt = S_START;
                    light_nxt = LAMP_RED;
                end
            endcase
            cnt_en_nxt = (state_nxt == S_RED) || (state_nxt == S_GREEN) || (state_nxt == S_YELLOW);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_START;
            light     <= LAMP_RED;
            init      <= INIT_NONE;
            cnt_en    <= 1'b0;
            ped_walk  <= 1'b0;
            ped_latch <= 1'b0;
            green_tmr <= '0;
            flash_tmr <= '0;
        end else begin
            state     <= state_nxt;
            light     <= light_nxt;
            init      <= init_nxt;
            cnt_en    <= cnt_en_nxt;
            ped_walk  <= ped_walk_nxt;
            ped_latch <= ped_latch_nxt;
            green_tmr <= green_tmr_nxt;
            flash_tmr <= flash_tmr_nxt;
        end
    end

endmodule

// File: tb/tb_light_phase_ctrl.sv
// Randomized bench for light_phase_ctrl: a phase-level reference model predicts each
// cycle's outputs into a queue that an independent monitor drains and compares.
module tb_light_phase_ctrl;

    localparam int MIN  = 4;
    localparam int HALF = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       last = 1'b0;
    logic       ped_req = 1'b0;
    logic       night_mode = 1'b0;
    logic [2:0] init;
    logic       cnt_en;
    logic [2:0] light;
    logic       ped_walk;
    logic [2:0] state_o;

    always #5 clk = ~clk;

    light_phase_ctrl #(
        .pINIT_WIDTH(3),
        .pMIN_GREEN (MIN),
        .pFLASH_HALF(HALF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .last      (last),
        .ped_req   (ped_req),
        .night_mode(night_mode),
        .init      (init),
        .cnt_en    (cnt_en),
        .light     (light),
        .ped_walk  (ped_walk),
        .state_o   (state_o)
    );

    typedef struct packed {
        logic [2:0] state;
        logic [2:0] light;
        logic [2:0] init;
        logic       cnt_en;
        logic       ped_walk;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: phase number, elapsed-cycle counts and a request flag.
    int         m_phase = 0;
    int         m_green_cycles = 0;
    int         m_flash_cycles = 0;
    bit         m_latch = 0;
    bit         m_walk = 0;
    bit         m_cnt = 0;
    logic [2:0] m_init = 3'b000;

    task automatic model_step();
        exp_t       e;
        bit         can_move;
        bit         new_latch;
        logic [2:0] new_init;
        int         nxt;
        if (rst) begin
            m_phase = 0; m_init = 3'b000; m_cnt = 0; m_walk = 0;
            m_latch = 0; m_green_cycles = 0; m_flash_cycles = 0;
        end else begin
            can_move  = (m_init == 3'b000);
            new_latch = m_latch | (ped_req && m_phase != 4);
            new_init  = 3'b000;
            nxt       = m_phase;
            if (en) begin
                case (m_phase)
                    0: if (night_mode) begin nxt = 4; m_flash_cycles = 0; end
                       else begin nxt = 1; new_init = 3'b100; end
                    1: if (last && can_move) begin
                           nxt = 2; new_init = 3'b001; m_green_cycles = 0; m_walk = 0;
                       end
                    2: begin
                           m_green_cycles++;
                           if (can_move && (last || (m_latch && m_green_cycles >= MIN))) begin
                               nxt = 3; new_init = 3'b010;
                           end
                       end
                    3: if (last && can_move) begin
                           if (night_mode) begin nxt = 4; m_flash_cycles = 0; end
                           else begin
                               nxt = 1; new_init = 3'b100; m_walk = m_latch; new_latch = ped_req;
                           end
                       end
                    default: if (!night_mode) begin nxt = 1; new_init = 3'b100; m_walk = 0; end
                             else m_flash_cycles++;
                endcase
                m_cnt = (nxt >= 1 && nxt <= 3);
            end else begin
                m_cnt = 0;
            end
            m_latch = new_latch;
            m_phase = nxt;
            m_init  = new_init;
        end
        e.state    = 3'(m_phase);
        e.init     = m_init;
        e.cnt_en   = m_cnt;
        e.ped_walk = m_walk;
        case (m_phase)
            2:       e.light = 3'b001;
            3:       e.light = 3'b010;
            4:       e.light = (((m_flash_cycles / HALF) % 2) == 0) ? 3'b010 : 3'b000;
            default: e.light = 3'b100;
        endcase
        q.push_back(e);
    endtask

    // Monitor: independent of stimulus, compares whatever the model has queued.
    logic [2:0] prev_init = 3'b000;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                tests++;
                if ({state_o, light, init, cnt_en, ped_walk} !== e) begin
                    fails++;
                    $display("FAIL cycle_check t=%0t got state=%0d light=%b init=%b cnt_en=%b walk=%b, expected state=%0d light=%b init=%b cnt_en=%b walk=%b",
                             $time, state_o, light, init, cnt_en, ped_walk,
                             e.state, e.light, e.init, e.cnt_en, e.ped_walk);
                end
                tests++;
                if (init !== 3'b000 && prev_init !== 3'b000) begin
                    fails++;
                    $display("FAIL init_back_to_back t=%0t got init=%b after %b, expected a zero cycle between pulses",
                             $time, init, prev_init);
                end
                prev_init = init;
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic segment(input int n, input int p_last, input int p_ped, input int p_night,
                           input int p_en_low, input int p_rst, input bit last_hold);
        for (int i = 0; i < n; i++) begin
            rst     = ($urandom_range(999) < p_rst);
            en      = ($urandom_range(99) >= p_en_low);
            last    = last_hold ? 1'b1 : ($urandom_range(99) < p_last);
            ped_req = ($urandom_range(99) < p_ped);
            if ($urandom_range(999) < p_night)
                night_mode = ~night_mode;
            cycle();
        end
    endtask

    initial begin
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        en  = 1'b1;
        segment(400, 20, 0, 0, 0, 0, 1'b0);
        segment(600, 10, 5, 0, 0, 0, 1'b0);
        segment(600, 25, 3, 15, 0, 0, 1'b0);
        night_mode = 1'b0;
        segment(500, 30, 10, 0, 30, 0, 1'b0);
        segment(300, 0, 5, 0, 0, 0, 1'b1);
        segment(800, 20, 8, 10, 15, 8, 1'b0);
        night_mode = 1'b0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        segment(200, 15, 20, 0, 0, 0, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL queue_drain got %0d entries left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
